// File: rtl/ecc_mod_pkg.sv
// Shared definitions for the serial ECC modular-arithmetic units.
// Default widths, the P-192 modulus and the common FSM state encoding.
package ecc_mod_pkg;

  localparam int DEF_DATA_WIDTH = 192;
  localparam int DEF_LIMB_WIDTH = 32;

  localparam logic [191:0] P192 =
    192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_sub_limb.sv
// One limb of the add chain and the trailing subtract-modulus chain.
// Purely combinational; the top carries carry/borrow between limbs.
module add_sub_limb #(
  parameter int LW = 32
) (
  input  logic [LW-1:0] a_i,
  input  logic [LW-1:0] b_i,
  input  logic [LW-1:0] m_i,
  input  logic          carry_in,
  input  logic          borrow_in,
  output logic [LW-1:0] sum_i,
  output logic [LW-1:0] diff_i,
  output logic          carry_out,
  output logic          borrow_out
);

  logic [LW:0] s;
  logic [LW:0] d;

  always_comb begin
    s = {1'b0, a_i} + {1'b0, b_i} + {{LW{1'b0}}, carry_in};
    d = {1'b0, s[LW-1:0]} - {1'b0, m_i}
      - {{LW{1'b0}}, borrow_in};
  end

  assign sum_i      = s[LW-1:0];
  assign carry_out  = s[LW];
  assign diff_i     = d[LW-1:0];
  assign borrow_out = d[LW];

endmodule

// File: rtl/add_mod_serial.sv
// Limb-serial modular adder: out = (opA + opB) mod opM.
// One limb of sum and sum-M per cycle, final pick on the last limb.
module add_mod_serial
  import ecc_mod_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LIMB_WIDTH = DEF_LIMB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  input  logic [DATA_WIDTH-1:0] opM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int NUM_LIMBS = DATA_WIDTH / LIMB_WIDTH;
  localparam int IW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_LIMBS - 1);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  carry_q, carry_d;
  logic                  borrow_q, borrow_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic [31:0]           lsb;
  logic [LIMB_WIDTH-1:0] a_l, b_l, m_l;
  logic [LIMB_WIDTH-1:0] sum_l, diff_l;
  logic                  carry_o, borrow_o;

  assign lsb = 32'(idx_q) * 32'(LIMB_WIDTH);
  assign a_l = a_q[lsb +: LIMB_WIDTH];
  assign b_l = b_q[lsb +: LIMB_WIDTH];
  assign m_l = m_q[lsb +: LIMB_WIDTH];

  add_sub_limb #(
    .LW(LIMB_WIDTH)
  ) u_limb (
    .a_i       (a_l),
    .b_i       (b_l),
    .m_i       (m_l),
    .carry_in  (carry_q),
    .borrow_in (borrow_q),
    .sum_i     (sum_l),
    .diff_i    (diff_l),
    .carry_out (carry_o),
    .borrow_out(borrow_o)
  );

  // in_ready is gated by rst_n so it reads 0 while reset is held
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    out_d    = out_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = opA;
          b_d      = opB;
          m_d      = opM;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          idx_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        sum_d[lsb +: LIMB_WIDTH]  = sum_l;
        diff_d[lsb +: LIMB_WIDTH] = diff_l;
        carry_d  = carry_o;
        borrow_d = borrow_o;
        if (idx_q == LAST) begin
          // sum >= M exactly when the add overflowed or sum-M did not borrow
          out_d   = (carry_o || !borrow_o) ? diff_d : sum_d;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: doc/add_mod_serial.md
Name: add_mod_serial

Overview:
- Limb-serial modular adder: returns (opA + opB) mod opM.
- Companion of the modular subtractor in the ECC modular-arithmetic library; the addition direction of the same field-arithmetic interface.
- Processes LIMB_WIDTH bits per cycle with a valid/ready handshake on input and output.
- Feeds point add/double sequencers where area matters more than latency.

Parameters:
- DATA_WIDTH, 192, operand/modulus width; must be an integer multiple of LIMB_WIDTH.
- LIMB_WIDTH, 32, bits processed per cycle. NUM_LIMBS = DATA_WIDTH/LIMB_WIDTH is a derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- opA  in  DATA_WIDTH  addend; must be < opM
- opB  in  DATA_WIDTH  addend; must be < opM
- opM  in  DATA_WIDTH  modulus; nonzero
- out_valid  out  1  out_data holds a valid result
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  (opA + opB) mod opM

Behaviour:
- Reset is asynchronous and active-low; clock is clk. While rst_n=0:
  - state=IDLE, in_ready=0 during reset then 1, out_valid=0, out_data=0.
  - Internal operand, sum and difference registers, carry, borrow and limb index are all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready: latch opA, opB, opM; clear carry, borrow and index; go to CALC.
  - Port values after the accept edge are ignored.
- CALC:
  - in_ready=0.
  - Each edge processes limb i = index: s = A_i + B_i + carry (LIMB_WIDTH+1 bits); sum_i = s[LIMB_WIDTH-1:0]; carry = s[LIMB_WIDTH].
  - In the same limb: d = sum_i - M_i - borrow; diff_i = d low bits; borrow = d negative.
  - Add and subtract chains run in the same cycle per limb.
  - On the edge processing limb NUM_LIMBS-1: go to DONE and register out_data using final carry c and borrow b of that limb.
    - c=1, or c=0 and b=0 (sum >= M): out_data = diff.
    - Otherwise: out_data = sum.
- DONE:
  - out_valid=1; out_data is held stable until the edge where out_ready=1.
  - On that edge: out_valid becomes 0 and state becomes IDLE.
  - in_ready=0 throughout DONE; in_valid asserted during DONE is not accepted.
- Latency: out_valid rises NUM_LIMBS edges after the accept edge (6 at defaults).
- Throughput: one result per NUM_LIMBS+2 cycles with out_ready held high.
- LIMB_WIDTH == DATA_WIDTH is legal: single CALC cycle.
- Preconditions: opA, opB < opM. If violated, the output follows the selection rule above deterministically, but the result is not guaranteed reduced.
- Reset asserted in any state aborts the operation immediately: out_valid=0 and no partial result is emitted.
- out_data changes only on the DONE-entry edge or on reset.

Decomposition:
- Shared package ecc_mod_pkg:
  - default DATA_WIDTH (192) and LIMB_WIDTH (32);
  - P192 modulus constant;
  - FSM state encoding (IDLE/CALC/DONE), shared with any future serial subMod/mulMod.
- One natural sub-module, add_sub_limb: combinational limb cell.
  - Inputs: A_i, B_i, M_i, carry_in, borrow_in.
  - Outputs: sum_i, diff_i, carry_out, borrow_out.
  - Instantiated once; the top holds the FSM, shift/index logic and registers.

Test Plan:
- Basic add, defaults, M=P192=FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF: A=5, B=7, out_ready=1 -> out_data=12; out_valid exactly 6 edges after accept, high 1 cycle.
- Exact-modulus boundary, M=P192: A=P192-1, B=1 -> out_data=0 (c=0, b=0 path).
- Carry-out path, M=P192: A=P192-1, B=P192-1 -> out_data=P192-2.
- No reduction: A=P192-1, B=0 -> P192-1. Small modulus M=13, A=9, B=8 -> 4. M=13, A=3, B=4 -> 7.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands -> out_data stable, in_ready=0, no second accept. Release out_ready -> IDLE; new op accepted next cycle with correct result.
- Reset mid-CALC: drop rst_n on the 3rd CALC cycle -> out_valid=0 and out_data=0 asynchronously, no result emitted. After release, A=1, B=2, M=13 -> 3 with nominal latency.
